// File: rtl/inst_rom_loader.sv
// inst_rom_loader
//   This block answers the core's instruction fetches from a word array.
//   It also provides a byte-stream port that writes a new program into that array.
//   Bytes arrive most-significant first. Each group of four is packed into one
//   32-bit word and written at the next word address.
//   While a load is in progress, cpu_hold_o stays high. The top level ORs it into
//   the core's reset, so the core never fetches from a half-written program.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   ce_i, addr_i  fetch enable and byte address from pc
//   inst_o        fetched word, combinational (NOP when masked)
//   load_start_i  pulse: begin loading at word 0
//   load_valid_i  load_byte_i / load_last_i are valid
//   load_byte_i   program byte, big-endian stream order
//   load_last_i   marks the final byte of the program
//   load_ready_o  a byte is accepted this cycle when valid & ready
//   load_done_o   one-cycle pulse when a load finishes
//   load_err_o    sticky: program did not fit; cleared by load_start_i
//   cpu_hold_o    high while a load is in progress
module inst_rom_loader #(
  parameter int          AW  = 10,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic        cpu_hold_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state_reg, state_next;
  // One bit wider than a word address, so "array full" can never alias word 0.
  logic [AW:0] wptr_reg, wptr_next;
  logic [1:0]  bcnt_reg, bcnt_next;
  logic [31:0] asm_reg, asm_next;
  logic        err_reg, err_next;

  logic [31:0] asm_merged;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [AW-1:0] mem_waddr;

  // No reset on the array: a program that is already loaded survives a core reset.
  logic [31:0] mem [0:(1<<AW)-1];

  // The byte address's two low bits select a byte within a word; fetches are word-only.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  // Current partial word with the incoming byte inserted at its big-endian slot.
  always_comb begin
    asm_merged = asm_reg;
    case (bcnt_reg)
      2'd0:    asm_merged[31:24] = load_byte_i;
      2'd1:    asm_merged[23:16] = load_byte_i;
      2'd2:    asm_merged[15:8]  = load_byte_i;
      default: asm_merged[7:0]   = load_byte_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      bcnt_reg  <= '0;
      asm_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      bcnt_reg  <= bcnt_next;
      asm_reg   <= asm_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    bcnt_next  = bcnt_reg;
    asm_next   = asm_reg;
    err_next   = err_reg;
    mem_we     = 1'b0;
    mem_waddr  = wptr_reg[AW-1:0];
    mem_wdata  = asm_merged;
    case (state_reg)
      IDLE: begin
        if (load_start_i) begin
          state_next = LOAD;
          wptr_next  = '0;
          bcnt_next  = '0;
          asm_next   = '0;
          err_next   = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid_i) begin
          bcnt_next = bcnt_reg + 2'd1;
          asm_next  = asm_merged;
          if (bcnt_reg == 2'd3 || load_last_i) begin
            // The word is complete. Clear the assembler so the next word's
            // unfilled low bytes read as zero.
            asm_next = '0;
            if (wptr_reg[AW]) begin
              err_next   = 1'b1;
              state_next = DONE;
            end else begin
              mem_we    = 1'b1;
              wptr_next = wptr_reg + (AW+1)'(1);
              if (load_last_i) state_next = DONE;
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Writes are blocked while rst is high, so a reset in the middle of a byte
  // transfer leaves the array unchanged.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    inst_o = NOP;
    if (ce_i && state_reg == IDLE && addr_i[31:AW+2] == '0)
      inst_o = mem[addr_i[AW+1:2]];
  end

  assign load_ready_o = (state_reg == LOAD);
  assign load_done_o  = (state_reg == DONE);
  assign load_err_o   = err_reg;
  assign cpu_hold_o   = (state_reg != IDLE);

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_byte;
  logic        load_ready, load_done, load_err, cpu_hold;

  always #5 clk = ~clk;

  inst_rom_loader #(.AW(AW), .NOP(32'h0)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
    .load_start_i(load_start), .load_valid_i(load_valid), .load_byte_i(load_byte),
    .load_last_i(load_last), .load_ready_o(load_ready), .load_done_o(load_done),
    .load_err_o(load_err), .cpu_hold_o(cpu_hold)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: the accepted bytes of the current program are kept in a queue.
  // A word is formed from its four bytes, with missing bytes read as zero.
  // The word is committed when its fourth byte arrives or when the stream ends.
  // mode: 0 idle, 1 loading, 2 finishing
  int          m_mode = 0;
  logic [7:0]  m_q[$];
  logic [31:0] m_mem[DEPTH];
  bit          m_known[DEPTH];
  bit          m_err = 0;
  int          m_n, m_w;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      m_err  = 0;
    end else if (m_mode == 0) begin
      if (load_start) begin
        m_mode = 1;
        m_q.delete();
        m_err = 0;
      end
    end else if (m_mode == 1) begin
      if (load_valid) begin
        m_q.push_back(load_byte);
        m_n = m_q.size();
        if (m_n % 4 == 0 || load_last) begin
          m_w = (m_n - 1) / 4;
          if (m_w >= DEPTH) begin
            m_err  = 1;
            m_mode = 2;
          end else begin
            m_word = 32'h0;
            for (int j = 0; j < 4; j++)
              if (4 * m_w + j < m_n) m_word[31-8*j -: 8] = m_q[4*m_w+j];
            m_mem[m_w]   = m_word;
            m_known[m_w] = 1;
            if (load_last) m_mode = 2;
          end
        end
      end
    end else begin
      m_mode = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'b0, load_ready}, {31'b0, m_mode == 1});
      chk("hold",  {31'b0, cpu_hold},   {31'b0, m_mode != 0});
      chk("done",  {31'b0, load_done},  {31'b0, m_mode == 2});
      chk("err",   {31'b0, load_err},   {31'b0, m_err});
      if (ce && m_mode == 0 && addr < 32'd16) begin
        if (m_known[addr[3:2]]) chk("inst", inst, m_mem[addr[3:2]]);
      end else begin
        chk("inst_nop", inst, 32'h0);
      end
      if (load_done === 1'b1) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stim[$];

  // Sends stim as one program. With gaps set, an idle cycle goes in before
  // each byte; that cycle carries a stray start, a random last flag and a
  // random fetch. When rst_after >= 0, the load is cut short by a reset after
  // that many bytes.
  task automatic run_load(input bit gaps, input int rst_after);
    bit rdy;
    int to;
    done_cnt   = 0;
    load_start = 1;
    cyc();
    load_start = 0;
    chk("err_cleared_by_start", {31'b0, load_err}, 32'h0);
    for (int i = 0; i < stim.size(); i++) begin
      if (rst_after == i) begin
        load_valid = 0;
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        chk("hold_after_rst", {31'b0, cpu_hold}, 32'h0);
        break;
      end
      if (gaps) begin
        load_valid = 0;
        load_byte  = 8'($urandom);
        load_last  = 1'($urandom);
        load_start = 1;
        ce         = 1;
        addr       = $urandom_range(0, 15);
        cyc();
        load_start = 0;
      end
      load_valid = 1;
      load_byte  = stim[i];
      load_last  = (i == stim.size() - 1);
      to = 0;
      do begin
        rdy = load_ready;
        cyc();
        to++;
      end while (!rdy && to < 20);
      if (!rdy) begin
        errors++;
        $display("FAIL handshake_timeout actual=not_ready required=ready");
      end
    end
    load_valid = 0;
    load_last  = 0;
    ce         = 0;
    cyc();
    cyc();
    chk("done_pulse_count", done_cnt, (rst_after >= 0) ? 32'd0 : 32'd1);
    $display("load of %0d bytes (gaps=%0d rst_after=%0d) err=%0d done_pulses=%0d",
             stim.size(), gaps, rst_after, load_err, done_cnt);
  endtask

  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
    ce   = 1;
    addr = a;
    #1;
    chk(name, inst, exp);
    $display("fetch addr=%h inst=%h", a, inst);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1; ce = 0; addr = 0; load_start = 0; load_valid = 0; load_byte = 0; load_last = 0;
    cyc();
    cyc();
    chk("rst_ready", {31'b0, load_ready}, 32'h0);
    chk("rst_done",  {31'b0, load_done},  32'h0);
    chk("rst_err",   {31'b0, load_err},   32'h0);
    chk("rst_hold",  {31'b0, cpu_hold},   32'h0);
    chk("rst_inst",  inst, 32'h0);
    rst = 0;
    chk_en = 1;
    cyc();

    // Two full words
    stim = {8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
    run_load(0, -1);
    fetch("t2_addr0", 32'h0, 32'h3401_0010);
    fetch("t2_addr4", 32'h4, 32'h3402_0020);
    fetch("t2_addr5", 32'h5, 32'h3402_0020);
    ce = 0;
    cyc();

    // Partial final word, with gaps and stray starts
    stim = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(1, -1);
    fetch("t3_addr0", 32'h0, 32'hAABB_CCDD);
    fetch("t3_addr4", 32'h4, 32'hEE00_0000);
    ce = 0;
    cyc();

    // Overflow: 17 bytes into a 4-word array
    stim.delete();
    for (int i = 0; i < 17; i++) stim.push_back(8'(i));
    run_load(1, -1);
    chk("t4_err_sticky", {31'b0, load_err}, 32'h1);
    chk("t4_ready_low", {31'b0, load_ready}, 32'h0);
    fetch("t4_addr12", 32'hC, 32'h0C0D_0E0F);
    fetch("t4_out_of_range", 32'h10, 32'h0);
    ce = 0;
    cyc();

    // The next load clears err (checked right after start inside run_load)
    stim = {8'h77};
    run_load(0, -1);
    fetch("t4b_addr0", 32'h0, 32'h7700_0000);
    ce = 0;
    cyc();

    // Reset after 6 bytes: first word kept, second word untouched
    stim = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    run_load(0, 6);
    fetch("t6_addr0", 32'h0, 32'h1112_1314);
    fetch("t6_addr4", 32'h4, 32'h0405_0607);
    ce = 0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
